axis_bram_bank_ctrl: RTL

- Parametrised AXI4-Stream to BRAM-bank controller: unpacks stream beats into 16-bit elements for NUM_BANKS external dual-port BRAMs, and packs bank reads back into stream beats.
- Replaces the fixed 4-bank demux/mux datapath and its external FSM with a single command-driven engine.
- Adds broadcast writes, backpressure-safe packed readout, tlast checking and command validation.
- Sits between the AXI DMA streams and the convolution operand BRAMs.

---
 rtl/bram_bank_pkg.sv | 25 ++
 rtl/bank_addr_gen.sv | 59 +++++
 rtl/axis_bram_bank_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bram_bank_pkg.sv
// Shared definitions for the stream-to-BRAM-bank controller: command op codes,
// engine states and the stream lane count helper.
package bram_bank_pkg;

  localparam int BANK_W = 5;

  typedef enum logic [1:0] {
    OP_WRITE_SEQ   = 2'd0,
    OP_WRITE_BCAST = 2'd1,
    OP_READ        = 2'd2,
    OP_RSVD        = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  function automatic int lanes(input int axis_w, input int data_w);
    return axis_w / data_w;
  endfunction

endpackage

// File: rtl/bank_addr_gen.sv
// Bank-major (bank, address) walker: addresses addr_start..addr_start+count-1
// in each bank from bank_start to bank_end; last_o flags the final element.
module bank_addr_gen
  import bram_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [BANK_W-1:0]     bank_start_i,
  input  logic [BANK_W-1:0]     bank_end_i,
  input  logic [ADDR_WIDTH-1:0] addr_start_i,
  input  logic [ADDR_WIDTH:0]   addr_count_i,
  output logic [BANK_W-1:0]     bank_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [BANK_W-1:0]     bank_q, bank_end_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_start_q;
  logic [ADDR_WIDTH:0]   elem_q, count_q;
  logic                  bank_done;

  assign bank_done = (elem_q == count_q - 1'b1);
  assign last_o    = bank_done && (bank_q == bank_end_q);
  assign bank_o    = bank_q;
  assign addr_o    = addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q       <= '0;
      bank_end_q   <= '0;
      addr_q       <= '0;
      addr_start_q <= '0;
      elem_q       <= '0;
      count_q      <= '0;
    end else if (load_i) begin
      bank_q       <= bank_start_i;
      bank_end_q   <= bank_end_i;
      addr_q       <= addr_start_i;
      addr_start_q <= addr_start_i;
      elem_q       <= '0;
      count_q      <= addr_count_i;
    end else if (advance_i) begin
      // Bank step and address reload happen together at the end of a bank.
      if (bank_done) begin
        elem_q <= '0;
        addr_q <= addr_start_q;
        bank_q <= bank_q + 1'b1;
      end else begin
        elem_q <= elem_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_bram_bank_ctrl.sv
// Command-driven engine moving 16-bit elements between AXI4-Stream beats and a
// set of external dual-port BRAM banks (sequential/broadcast write, packed read).
module axis_bram_bank_ctrl
  import bram_bank_pkg::*;
#(
  parameter int NUM_BANKS  = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int AXIS_WIDTH = 64
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [BANK_W-1:0]               cmd_bank_start,
  input  logic [BANK_W-1:0]               cmd_bank_end,
  input  logic [ADDR_WIDTH:0]             cmd_addr_start,
  input  logic [ADDR_WIDTH:0]             cmd_addr_count,
  input  logic [AXIS_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [AXIS_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [NUM_BANKS-1:0]            bank_wr_en,
  output logic [ADDR_WIDTH-1:0]           bank_wr_addr,
  output logic [DATA_WIDTH-1:0]           bank_wr_data,
  output logic [NUM_BANKS-1:0]            bank_rd_en,
  output logic [ADDR_WIDTH-1:0]           bank_rd_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rd_data,
  output logic                            busy,
  output logic                            done,
  output logic                            cmd_err,
  output logic                            tlast_err
);

  localparam int LANES  = lanes(AXIS_WIDTH, DATA_WIDTH);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0]     LAST_LANE  = LANE_W'(LANES - 1);
  localparam logic [ADDR_WIDTH+1:0] ADDR_LIMIT = (ADDR_WIDTH + 2)'(1) << ADDR_WIDTH;

  state_e                state_q;
  op_e                   op_q, cmd_op_e;
  logic [BANK_W-1:0]     bank_start_q, bank_end_q;
  logic [LANE_W-1:0]     wr_lane_q, rd_lane_q, rd_pend_lane_q;
  logic                  rd_pend_q, rd_pend_end_q, rd_pend_last_q;
  logic [BANK_W-1:0]     rd_pend_bank_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] pack_q, pack_d;
  logic [AXIS_WIDTH-1:0] out_data_q;
  logic                  out_valid_q, out_last_q;
  logic                  done_q, cmd_err_q, tlast_err_q;

  logic [ADDR_WIDTH+1:0] addr_end;
  logic                  cmd_bad, cmd_load;
  logic [BANK_W-1:0]     wr_bank_end, wr_bank, rd_bank;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  wr_last, rd_last, wr_fire, rd_issue, rd_issue_end, out_hs;
  logic [DATA_WIDTH-1:0] wr_elem, rd_elem;

  assign cmd_op_e = op_e'(cmd_op);
  assign addr_end = {1'b0, cmd_addr_start} + {1'b0, cmd_addr_count};
  assign cmd_bad  = (cmd_bank_start > cmd_bank_end)
                 || ({1'b0, cmd_bank_end} >= (BANK_W + 1)'(NUM_BANKS))
                 || (cmd_addr_count == '0)
                 || (addr_end > ADDR_LIMIT)
                 || (cmd_op_e == OP_RSVD);
  assign cmd_load = (state_q == ST_IDLE) && cmd_valid && !cmd_bad;

  // A broadcast walks the address range once; the bank mask fans it out.
  assign wr_bank_end = (cmd_op_e == OP_WRITE_BCAST) ? cmd_bank_start : cmd_bank_end;

  bank_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_gen (
    .clk_i(aclk), .rst_ni(aresetn), .load_i(cmd_load), .advance_i(wr_fire),
    .bank_start_i(cmd_bank_start), .bank_end_i(wr_bank_end),
    .addr_start_i(cmd_addr_start[ADDR_WIDTH-1:0]), .addr_count_i(cmd_addr_count),
    .bank_o(wr_bank), .addr_o(wr_addr), .last_o(wr_last)
  );

  bank_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_gen (
    .clk_i(aclk), .rst_ni(aresetn), .load_i(cmd_load), .advance_i(rd_issue),
    .bank_start_i(cmd_bank_start), .bank_end_i(cmd_bank_end),
    .addr_start_i(cmd_addr_start[ADDR_WIDTH-1:0]), .addr_count_i(cmd_addr_count),
    .bank_o(rd_bank), .addr_o(rd_addr), .last_o(rd_last)
  );

  assign wr_fire       = (state_q == ST_WRITE) && s_axis_tvalid;
  assign s_axis_tready = wr_fire && ((wr_lane_q == LAST_LANE) || wr_last);

  assign out_hs       = out_valid_q && m_axis_tready;
  assign rd_issue_end = (rd_lane_q == LAST_LANE) || rd_last;
  // Hold issue while a beat is stuck, and never let two beat-completing reads
  // land back to back into a single output register.
  assign rd_issue = (state_q == ST_READ) && !(out_valid_q && !m_axis_tready)
                 && !(rd_issue_end && rd_pend_q && rd_pend_end_q);

  always_comb begin
    wr_elem = '0;
    for (int l = 0; l < LANES; l++) begin
      if (wr_lane_q == LANE_W'(l)) wr_elem = s_axis_tdata[l*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    rd_elem = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_pend_bank_q == BANK_W'(b)) rd_elem = bank_rd_data[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    pack_d = pack_q;
    for (int l = 0; l < LANES; l++) begin
      if (rd_pend_lane_q == LANE_W'(l)) pack_d[l] = rd_elem;
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    localparam logic [BANK_W-1:0] BANK_ID = BANK_W'(gi);
    assign bank_wr_en[gi] = wr_fire && ((op_q == OP_WRITE_BCAST)
                          ? ((BANK_ID >= bank_start_q) && (BANK_ID <= bank_end_q))
                          : (wr_bank == BANK_ID));
    assign bank_rd_en[gi] = rd_issue && (rd_bank == BANK_ID);
  end

  assign bank_wr_addr  = (state_q == ST_WRITE) ? wr_addr : '0;
  assign bank_wr_data  = (state_q == ST_WRITE) ? wr_elem : '0;
  assign bank_rd_addr  = (state_q == ST_READ) ? rd_addr : '0;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign cmd_err       = cmd_err_q;
  assign tlast_err     = tlast_err_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_WRITE_SEQ;
      bank_start_q <= '0;
      bank_end_q   <= '0;
      wr_lane_q    <= '0;
      done_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
      tlast_err_q  <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      tlast_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              cmd_err_q <= 1'b1;
            end else begin
              op_q         <= cmd_op_e;
              bank_start_q <= cmd_bank_start;
              bank_end_q   <= cmd_bank_end;
              wr_lane_q    <= '0;
              state_q      <= (cmd_op_e == OP_READ) ? ST_READ : ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (wr_fire) begin
            wr_lane_q <= s_axis_tready ? '0 : wr_lane_q + 1'b1;
            if (s_axis_tready && (s_axis_tlast != wr_last)) tlast_err_q <= 1'b1;
            if (wr_last) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (rd_issue && rd_last) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (out_hs && out_last_q) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_lane_q      <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_end_q  <= 1'b0;
      rd_pend_last_q <= 1'b0;
      rd_pend_lane_q <= '0;
      rd_pend_bank_q <= '0;
      pack_q         <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
    end else begin
      if (cmd_load) begin
        rd_lane_q <= '0;
      end else if (rd_issue) begin
        rd_lane_q <= rd_issue_end ? '0 : rd_lane_q + 1'b1;
      end
      rd_pend_q      <= rd_issue;
      rd_pend_end_q  <= rd_issue_end;
      rd_pend_last_q <= rd_last;
      rd_pend_lane_q <= rd_lane_q;
      rd_pend_bank_q <= rd_bank;
      if (out_hs) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      // Returned element lands one cycle after issue; lanes above it stay zero.
      if (rd_pend_q) begin
        if (rd_pend_end_q) begin
          out_data_q  <= pack_d;
          out_valid_q <= 1'b1;
          out_last_q  <= rd_pend_last_q;
          pack_q      <= '0;
        end else begin
          pack_q <= pack_d;
        end
      end
    end
  end

endmodule
